// File: rtl/ice40_reset_seq_pkg.sv
// Shared definitions for the iCE40 reset/clock sequencing blocks.
// State encodings and constant helpers used to size counters.
package ice40_reset_seq_pkg;

    typedef enum logic [1:0] {
        S_POR  = 2'd0,
        S_HOLD = 2'd1,
        S_REL  = 2'd2,
        S_RUN  = 2'd3
    } seq_state_e;

    function automatic int clog2(input int v);
        int r;
        int x;
        r = 0;
        x = v - 1;
        while (x > 0) begin
            r = r + 1;
            x = x >> 1;
        end
        return r;
    endfunction

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/ice40_reset_seq_if.sv
// Reset sequencer control/status bundle.
// master = the sequencer, slave = the block consuming the resets.
interface ice40_reset_seq_if #(
    parameter int N_CH = 4
);
    logic            soft_rst_req;
    logic [N_CH-1:0] rst_n_out;
    logic            por_done;
    logic            seq_busy;

    modport master (
        input  soft_rst_req,
        output rst_n_out,
        output por_done,
        output seq_busy
    );

    modport slave (
        output soft_rst_req,
        input  rst_n_out,
        input  por_done,
        input  seq_busy
    );
endinterface

// File: rtl/ice40_reset_timer.sv
// Loadable down-counter shared by the hold and stagger phases.
// tick marks the edge on which the count reaches zero.
module ice40_reset_timer #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         tick
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign tick = (cnt_q == W'(1));

endmodule

// File: rtl/ice40_reset_seq.sv
// Power-on reset sequencer: POR delay, then staggered in-order
// release of N_CH active-low reset channels, with soft re-sequence.
module ice40_reset_seq
    import ice40_reset_seq_pkg::*;
#(
    parameter int POR_BITS    = 8,
    parameter int N_CH        = 4,
    parameter int HOLD_CYCLES = 16,
    parameter int STAGGER     = 8
) (
    input  logic                clk,
    input  logic                resetn,
    ice40_reset_seq_if.master   bus
);

    localparam int TW = clog2(max2(HOLD_CYCLES, STAGGER) + 1);
    localparam int CW = clog2(N_CH + 1);

    localparam logic [POR_BITS-1:0] POR_ALL  = {POR_BITS{1'b1}};
    localparam logic [POR_BITS-1:0] POR_LAST = POR_ALL - 1'b1;
    localparam logic [CW-1:0]       CH_LAST  = CW'(N_CH - 1);
    localparam logic [TW-1:0]       T_HOLD   = TW'(HOLD_CYCLES);
    localparam logic [TW-1:0]       T_STAG   = TW'(STAGGER);

    seq_state_e          state_q, state_d;
    logic [POR_BITS-1:0] por_q, por_d;
    logic [CW-1:0]       ch_q, ch_d;
    logic [N_CH-1:0]     rst_q, rst_d;
    logic [N_CH-1:0]     rst_shift;
    logic                done_q, done_d;
    logic                idle_q, idle_d;
    logic                tmr_load;
    logic [TW-1:0]       tmr_val;
    logic                tmr_tick;

    ice40_reset_timer #(
        .W (TW)
    ) u_timer (
        .clk      (clk),
        .resetn   (resetn),
        .load     (tmr_load),
        .load_val (tmr_val),
        .tick     (tmr_tick)
    );

    // Thermometer step: release the next channel above the released ones.
    always_comb begin
        rst_shift = '0;
        rst_shift[0] = 1'b1;
        for (int i = 1; i < N_CH; i++) begin
            rst_shift[i] = rst_q[i-1];
        end
    end

    always_comb begin
        state_d  = state_q;
        por_d    = por_q;
        ch_d     = ch_q;
        rst_d    = rst_q;
        done_d   = done_q;
        idle_d   = idle_q;
        tmr_load = 1'b0;
        tmr_val  = T_HOLD;

        unique case (state_q)
            S_POR: begin
                if (por_q != POR_ALL) begin
                    por_d = por_q + 1'b1;
                end
                if (por_q == POR_LAST) begin
                    done_d   = 1'b1;
                    state_d  = S_HOLD;
                    tmr_load = 1'b1;
                end
            end
            S_HOLD, S_REL, S_RUN: begin
                if (bus.soft_rst_req) begin
                    state_d  = S_HOLD;
                    rst_d    = '0;
                    ch_d     = '0;
                    idle_d   = 1'b0;
                    tmr_load = 1'b1;
                end else if (state_q != S_RUN && tmr_tick) begin
                    rst_d = rst_shift;
                    if (ch_q == CH_LAST) begin
                        state_d = S_RUN;
                        idle_d  = 1'b1;
                    end else begin
                        state_d  = S_REL;
                        ch_d     = ch_q + 1'b1;
                        tmr_load = 1'b1;
                        tmr_val  = T_STAG;
                    end
                end
            end
        endcase
    end

    // All reset values are zero so configuration-time init matches reset.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= S_POR;
            por_q   <= '0;
            ch_q    <= '0;
            rst_q   <= '0;
            done_q  <= 1'b0;
            idle_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            por_q   <= por_d;
            ch_q    <= ch_d;
            rst_q   <= rst_d;
            done_q  <= done_d;
            idle_q  <= idle_d;
        end
    end

    assign bus.rst_n_out = rst_q;
    assign bus.por_done  = done_q;
    assign bus.seq_busy  = ~idle_q;

endmodule

// File: tb/tb_ice40_reset_seq.sv
// Bench for ice40_reset_seq: table vectors, directed corner sequences
// and random soft/hard resets against a timing-rule reference model.
module tb_ice40_reset_seq;

    localparam int POR_EDGES = 15;

    logic clk = 1'b0;
    logic resetn;

    ice40_reset_seq_if #(.N_CH(3)) bus();
    ice40_reset_seq_if #(.N_CH(1)) bus1();

    ice40_reset_seq #(
        .POR_BITS    (4),
        .N_CH        (3),
        .HOLD_CYCLES (2),
        .STAGGER     (3)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    ice40_reset_seq #(
        .POR_BITS    (4),
        .N_CH        (1),
        .HOLD_CYCLES (1),
        .STAGGER     (3)
    ) dut1 (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus1)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    int edge_n = 0;
    int since  = 0;
    int start  = 0;
    bit have_start = 1'b0;

    typedef struct {
        int         e;
        logic [2:0] rst;
        logic       done;
        logic       busy;
        logic       rst1;
        logic       busy1;
    } vec_t;

    vec_t tbl[9];

    task automatic check(input string name, input logic [7:0] got,
                         input logic [7:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s edge %0d: got %b want %b",
                     name, edge_n, got, exp);
        end
    endtask

    // Channels released n edges after a sequence start at 'start'.
    function automatic int exp_k(input int nch, input int h, input int s);
        int d;
        int k;
        if (!have_start) return 0;
        d = edge_n - start;
        if (d < h) return 0;
        k = 1 + (d - h) / s;
        return (k > nch) ? nch : k;
    endfunction

    task automatic step(input logic rn, input logic sr);
        int k3;
        int k1;
        @(negedge clk);
        resetn = rn;
        bus.soft_rst_req  = sr;
        bus1.soft_rst_req = sr;
        @(posedge clk);
        edge_n++;
        if (!rn) begin
            since = 0;
            have_start = 1'b0;
        end else begin
            if (since < 1000) since++;
            if (since == POR_EDGES) begin
                have_start = 1'b1;
                start = edge_n;
            end else if (since > POR_EDGES && sr) begin
                have_start = 1'b1;
                start = edge_n;
            end
        end
        #1;
        k3 = exp_k(3, 2, 3);
        k1 = exp_k(1, 1, 3);
        check("no_x", 8'($isunknown({bus.rst_n_out, bus.por_done,
              bus.seq_busy, bus1.rst_n_out, bus1.por_done,
              bus1.seq_busy})), 8'd0);
        check("rst_n_out", 8'(bus.rst_n_out), 8'((1 << k3) - 1));
        check("por_done", 8'(bus.por_done), 8'(since >= POR_EDGES));
        check("seq_busy", 8'(bus.seq_busy), 8'(k3 < 3));
        check("rst_n_out_n1", 8'(bus1.rst_n_out), 8'(k1));
        check("por_done_n1", 8'(bus1.por_done), 8'(since >= POR_EDGES));
        check("seq_busy_n1", 8'(bus1.seq_busy), 8'(k1 < 1));
    endtask

    initial begin
        int cnt;
        resetn = 1'b0;
        bus.soft_rst_req  = 1'b0;
        bus1.soft_rst_req = 1'b0;

        tbl[0] = '{14, 3'b000, 1'b0, 1'b1, 1'b0, 1'b1};
        tbl[1] = '{15, 3'b000, 1'b1, 1'b1, 1'b0, 1'b1};
        tbl[2] = '{16, 3'b000, 1'b1, 1'b1, 1'b1, 1'b0};
        tbl[3] = '{17, 3'b001, 1'b1, 1'b1, 1'b1, 1'b0};
        tbl[4] = '{19, 3'b001, 1'b1, 1'b1, 1'b1, 1'b0};
        tbl[5] = '{20, 3'b011, 1'b1, 1'b1, 1'b1, 1'b0};
        tbl[6] = '{22, 3'b011, 1'b1, 1'b1, 1'b1, 1'b0};
        tbl[7] = '{23, 3'b111, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[8] = '{25, 3'b111, 1'b1, 1'b0, 1'b1, 1'b0};

        step(1'b0, 1'b0);
        step(1'b0, 1'b0);

        // Power-up sequence against the vector table.
        for (int e = 1; e <= 25; e++) begin
            step(1'b1, 1'b0);
            for (int j = 0; j < 9; j++) begin
                if (tbl[j].e == since) begin
                    check("tbl_rst", 8'(bus.rst_n_out), 8'(tbl[j].rst));
                    check("tbl_done", 8'(bus.por_done), 8'(tbl[j].done));
                    check("tbl_busy", 8'(bus.seq_busy), 8'(tbl[j].busy));
                    check("tbl_rst1", 8'(bus1.rst_n_out), 8'(tbl[j].rst1));
                    check("tbl_busy1", 8'(bus1.seq_busy), 8'(tbl[j].busy1));
                end
            end
        end

        // Soft pulse in run: channel 0 back two edges later.
        step(1'b1, 1'b1);
        check("soft_clear", 8'(bus.rst_n_out), 8'd0);
        cnt = 0;
        while (bus.rst_n_out[0] !== 1'b1 && cnt < 10) begin
            step(1'b1, 1'b0);
            cnt++;
        end
        check("soft_to_ch0", 8'(cnt), 8'd2);
        repeat (8) step(1'b1, 1'b0);

        // Hard reset in run: POR reruns in full.
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        cnt = 0;
        while (bus.por_done !== 1'b1 && cnt < 30) begin
            step(1'b1, 1'b0);
            cnt++;
        end
        check("por_rerun", 8'(cnt), 8'(POR_EDGES));

        // Soft request mid-release, then a request held high.
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        check("mid_rel_pre", 8'(bus.rst_n_out), 8'b001);
        step(1'b1, 1'b1);
        repeat (12) step(1'b1, 1'b0);
        repeat (6) step(1'b1, 1'b1);
        check("held_soft", 8'(bus.rst_n_out), 8'd0);
        repeat (10) step(1'b1, 1'b0);

        // Reset and soft together; soft during POR is ignored.
        step(1'b0, 1'b1);
        step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        repeat (4) step(1'b1, 1'b1);
        repeat (30) step(1'b1, 1'b0);

        // Random soft and hard resets.
        for (int i = 0; i < 400; i++) begin
            step(logic'($urandom_range(0, 59) != 0),
                 logic'($urandom_range(0, 11) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
